vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_timing_gen_axis.sv | 48 ++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60; the helpers derive totals, counter widths and sync windows.
package vga_timing_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;
  localparam sync_pol_e DEF_SYNC_POL = SYNC_ACTIVE_LOW;
  localparam int DEF_SCALE_SHIFT = 1;
  localparam int DEF_ADDR_W      = 17;
  localparam int CNT_W           = 10;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int pos_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  function automatic logic in_sync(input int pos, input int active,
                                   input int front, input int sync);
    return (pos >= active + front) && (pos < active + front + sync);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter with wrap, plus sync and active decode of the
// position about to be entered. Parking forces the last position and idle sync level.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE   = DEF_H_ACTIVE,
  parameter int   FRONT    = DEF_H_FRONT,
  parameter int   SYNC     = DEF_H_SYNC,
  parameter int   BACK     = DEF_H_BACK,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  localparam int  TOTAL    = axis_total(ACTIVE, FRONT, SYNC, BACK),
  localparam int  PW       = pos_width(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          park,
  output logic [PW-1:0] pos_d,
  output logic          active_d,
  output logic          sync_q
);

  localparam logic [PW-1:0] LAST = PW'(TOTAL - 1);

  logic [PW-1:0] pos_q;
  logic          sync_d;

  always_comb begin
    pos_d = pos_q;
    if (park)      pos_d = LAST;
    else if (step) pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    active_d = !park && (int'(pos_d) < ACTIVE);
    sync_d = sync_q;
    if (park)      sync_d = ~SYNC_POL;
    else if (step) sync_d = in_sync(int'(pos_d), ACTIVE, FRONT, SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= LAST;
      sync_q <= ~SYNC_POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a scaled, incremental framebuffer address path.
// All outputs are registered and describe the raster position entered on a pix_ce edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_POL    = DEF_SYNC_POL,
  parameter int   SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int   ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [CNT_W-1:0]  h_cnt,
  output logic [CNT_W-1:0]  v_cnt,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              line_start,
  output logic              frame_start
);

  localparam int HW  = pos_width(axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
  localparam int VW  = pos_width(axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
  localparam int VW1 = VW + 1;
  localparam int SW  = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

  localparam logic [SW-1:0]     SUB_MAX  = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW1-1:0]    ROW_MASK = VW1'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [HW-1:0]     H_END    = HW'(H_ACTIVE);
  localparam logic [VW-1:0]     V_END    = VW'(V_ACTIVE);

  logic          adv, park, h_wrap;
  logic [HW-1:0] h_pos_d;
  logic [VW-1:0] v_pos_d;
  logic          h_act_d, v_act_d;

  assign adv    = pix_ce && en;
  assign park   = !en;
  assign h_wrap = adv && (h_pos_d == '0);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(adv), .park(park),
    .pos_d(h_pos_d), .active_d(h_act_d), .sync_q(hsync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(h_wrap), .park(park),
    .pos_d(v_pos_d), .active_d(v_act_d), .sync_q(vsync)
  );

  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, col_q, col_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [VW1-1:0]    v_next_line;
  logic              row_adv;

  always_comb begin
    valid_d       = valid_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pixel_addr_d  = pixel_addr_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    row_base_d    = row_base_q;
    col_d         = col_q;
    sub_d         = sub_q;
    // Row base steps after the last line of each group of 2^SCALE_SHIFT replicated lines.
    v_next_line   = {1'b0, v_pos_d} + 1'b1;
    row_adv       = (v_pos_d < V_END) && ((v_next_line & ROW_MASK) == '0);
    if (!en) begin
      valid_d      = 1'b0;
      h_cnt_d      = '0;
      v_cnt_d      = '0;
      pixel_addr_d = '0;
    end else if (pix_ce) begin
      valid_d       = h_act_d && v_act_d;
      h_cnt_d       = valid_d ? CNT_W'(h_pos_d) : '0;
      v_cnt_d       = valid_d ? CNT_W'(v_pos_d) : '0;
      line_start_d  = (h_pos_d == '0);
      frame_start_d = line_start_d && (v_pos_d == '0);
      if (h_pos_d == '0) begin
        col_d = '0;
        sub_d = '0;
        if (v_pos_d == '0) row_base_d = base_addr;
      end else if (valid_d) begin
        sub_d = (sub_q == SUB_MAX) ? '0 : sub_q + 1'b1;
        if (sub_q == SUB_MAX) col_d = col_q + 1'b1;
      end
      if ((h_pos_d == H_END) && row_adv) row_base_d = row_base_q + ROW_STEP;
      if (valid_d) pixel_addr_d = row_base_d + col_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_addr_q  <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      row_base_q    <= '0;
      col_q         <= '0;
      sub_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_addr_q  <= pixel_addr_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      row_base_q    <= row_base_d;
      col_q         <= col_d;
      sub_q         <= sub_d;
    end
  end

  assign valid       = valid_q;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign pixel_addr  = pixel_addr_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
